// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer and its surroundings: time and
// alarm settings, button pulses and the 1 Hz tick in; ring/snooze indications out.
interface alarm_sequencer_if;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_armed;
    logic       clock_mode;
    logic       btn_stop;
    logic       btn_snooze;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic       alarm_led;
    logic [8:0] snooze_left;
    logic [2:0] snoozes_used;

    modport slave (
        input  tick_1hz, cur_hour, cur_min, alarm_hour, alarm_min,
        input  alarm_armed, clock_mode, btn_stop, btn_snooze,
        output ringing, snoozing, buzzer, alarm_led, snooze_left, snoozes_used
    );

    modport master (
        output tick_1hz, cur_hour, cur_min, alarm_hour, alarm_min,
        output alarm_armed, clock_mode, btn_stop, btn_snooze,
        input  ringing, snoozing, buzzer, alarm_led, snooze_left, snoozes_used
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: triggers on the rising edge of a time/alarm match, then
// rings, snoozes and times out under button and 1 Hz tick control.
module alarm_sequencer #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic             clk,
    input  logic             rst,
    alarm_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_S);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZES);

    state_t     state, state_nx;
    logic [7:0] ring_cnt, ring_cnt_nx;
    logic       blink, blink_nx;
    logic [8:0] snooze_left_nx;
    logic [2:0] snoozes_used_nx;
    logic       match, match_d, match_rise;
    logic       stop_req;

    assign match      = (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
    assign match_rise = match & ~match_d;
    assign stop_req   = ~bus.alarm_armed | bus.btn_stop;

    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_nx        = state;
        ring_cnt_nx     = ring_cnt;
        blink_nx        = blink;
        snooze_left_nx  = bus.snooze_left;
        snoozes_used_nx = bus.snoozes_used;

        case (state)
            IDLE: begin
                if (match_rise && bus.alarm_armed && bus.clock_mode) begin
                    state_nx        = RING;
                    ring_cnt_nx     = 8'd0;
                    blink_nx        = 1'b1;
                    snoozes_used_nx = 3'd0;
                end
            end
            RING: begin
                if (stop_req) begin
                    state_nx       = IDLE;
                    ring_cnt_nx    = 8'd0;
                    blink_nx       = 1'b0;
                    snooze_left_nx = 9'd0;
                end else if (bus.btn_snooze) begin
                    // An exhausted snooze press still swallows a coincident tick.
                    if (bus.snoozes_used < SNOOZE_MAX) begin
                        state_nx        = SNOOZE;
                        snooze_left_nx  = SNOOZE_LOAD;
                        snoozes_used_nx = bus.snoozes_used + 3'd1;
                    end
                end else if (bus.tick_1hz) begin
                    if (ring_cnt == RING_LAST) begin
                        state_nx       = IDLE;
                        ring_cnt_nx    = 8'd0;
                        blink_nx       = 1'b0;
                        snooze_left_nx = 9'd0;
                    end else begin
                        ring_cnt_nx = ring_cnt + 8'd1;
                        blink_nx    = ~blink;
                    end
                end
            end
            SNOOZE: begin
                if (stop_req) begin
                    state_nx       = IDLE;
                    ring_cnt_nx    = 8'd0;
                    blink_nx       = 1'b0;
                    snooze_left_nx = 9'd0;
                end else if (bus.tick_1hz) begin
                    if (bus.snooze_left == 9'd1) begin
                        state_nx       = RING;
                        ring_cnt_nx    = 8'd0;
                        blink_nx       = 1'b1;
                        snooze_left_nx = 9'd0;
                    end else begin
                        snooze_left_nx = bus.snooze_left - 9'd1;
                    end
                end
            end
            default: begin
                state_nx       = IDLE;
                ring_cnt_nx    = 8'd0;
                blink_nx       = 1'b0;
                snooze_left_nx = 9'd0;
            end
        endcase
    end

    // match_d resets high so a match already present at reset release is not an edge.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            ring_cnt         <= 8'd0;
            blink            <= 1'b0;
            match_d          <= 1'b1;
            bus.snooze_left  <= 9'd0;
            bus.snoozes_used <= 3'd0;
            bus.ringing      <= 1'b0;
            bus.snoozing     <= 1'b0;
            bus.buzzer       <= 1'b0;
            bus.alarm_led    <= 1'b0;
        end else begin
            state            <= state_nx;
            ring_cnt         <= ring_cnt_nx;
            blink            <= blink_nx;
            match_d          <= match;
            bus.snooze_left  <= snooze_left_nx;
            bus.snoozes_used <= snoozes_used_nx;
            bus.ringing      <= (state_nx == RING);
            bus.snoozing     <= (state_nx == SNOOZE);
            bus.buzzer       <= (state_nx == RING) & blink_nx;
            bus.alarm_led    <= (state_nx == RING) ? blink_nx : (state_nx == SNOOZE);
        end
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: a fixed vector table, hand-written corner-case
// sequences, then random stimulus against an event-level reference model.
module tb_alarm_sequencer;
    localparam int RING_TIMEOUT_S = 60;
    localparam int SNOOZE_S       = 5;
    localparam int MAX_SNOOZES    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .SNOOZE_S      (SNOOZE_S),
        .MAX_SNOOZES   (MAX_SNOOZES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 ringing, 2 snoozing. Blink is derived
    // from the seconds rung so far (lit on even seconds).
    int m_phase, m_ring_secs, m_left, m_used;
    bit m_prev_match;

    typedef struct {
        logic [5:0] cm;
        logic       armed, mode, tick, stop, snz;
        logic       r, s, bz, led;
        logic [8:0] left;
        logic [2:0] used;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_ring_secs  = 0;
        m_left       = 0;
        m_used       = 0;
        m_prev_match = 1'b1;
    endtask

    task automatic model_step(input int hr, input int mn, input bit armed, input bit mode,
                              input bit tick, input bit stop, input bit snz);
        bit match;
        match = (hr == 7) && (mn == 30);
        if (m_phase == 0) begin
            if (match && !m_prev_match && armed && mode) begin
                m_phase = 1; m_ring_secs = 0; m_used = 0;
            end
        end else if (!armed || stop) begin
            m_phase = 0; m_ring_secs = 0; m_left = 0;
        end else if (m_phase == 1) begin
            if (snz) begin
                if (m_used < MAX_SNOOZES) begin
                    m_phase = 2; m_left = SNOOZE_S; m_used++;
                end
            end else if (tick) begin
                m_ring_secs++;
                if (m_ring_secs == RING_TIMEOUT_S) begin
                    m_phase = 0; m_ring_secs = 0;
                end
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 1; m_ring_secs = 0;
            end
        end
        m_prev_match = match;
    endtask

    task automatic compare_model(input string tag);
        bit lit;
        lit = (m_phase == 1) && (m_ring_secs % 2 == 0);
        check({tag, " ringing"},      16'(bus.ringing),      16'(m_phase == 1));
        check({tag, " snoozing"},     16'(bus.snoozing),     16'(m_phase == 2));
        check({tag, " buzzer"},       16'(bus.buzzer),       16'(lit));
        check({tag, " alarm_led"},    16'(bus.alarm_led),    16'(lit || m_phase == 2));
        check({tag, " snooze_left"},  16'(bus.snooze_left),  16'(m_phase == 2 ? m_left : 0));
        check({tag, " snoozes_used"}, 16'(bus.snoozes_used), 16'(m_used));
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the next rising edge.
    task automatic step(input int hr, input int mn, input bit armed, input bit mode,
                        input bit tick, input bit stop, input bit snz);
        bus.cur_hour    = 5'(hr);
        bus.cur_min     = 6'(mn);
        bus.alarm_armed = armed;
        bus.clock_mode  = mode;
        bus.tick_1hz    = tick;
        bus.btn_stop    = stop;
        bus.btn_snooze  = snz;
        model_step(hr, mn, armed, mode, tick, stop, snz);
        @(posedge clk);
        #1;
        bus.tick_1hz   = 1'b0;
        bus.btn_stop   = 1'b0;
        bus.btn_snooze = 1'b0;
    endtask

    task automatic trigger(input string tag);
        step(7, 31, 1, 1, 0, 0, 0);
        step(7, 30, 1, 1, 0, 0, 0);
        check({tag, " trigger ringing"}, 16'(bus.ringing), 16'd1);
        check({tag, " trigger buzzer"},  16'(bus.buzzer),  16'd1);
    endtask

    function automatic vec_t v(input int cm, input bit a, input bit m, input bit t, input bit st,
                               input bit sn, input bit r, input bit s, input bit bz,
                               input bit led, input int left, input int used);
        vec_t x;
        x.cm = 6'(cm); x.armed = a; x.mode = m; x.tick = t; x.stop = st; x.snz = sn;
        x.r = r; x.s = s; x.bz = bz; x.led = led; x.left = 9'(left); x.used = 3'(used);
        return x;
    endfunction

    initial begin
        //             min a  m  t  st sn   r  s  bz led left used
        tbl.push_back(v(29, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0));
        tbl.push_back(v(30, 1, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  1, 0, 0, 0,  0, 0));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  1, 0, 1, 1,  0, 0));
        tbl.push_back(v(30, 1, 1, 0, 0, 1,  0, 1, 0, 1,  5, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  0, 1, 0, 1,  4, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  0, 1, 0, 1,  3, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  0, 1, 0, 1,  2, 1));
        tbl.push_back(v(30, 1, 1, 0, 0, 1,  0, 1, 0, 1,  2, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  0, 1, 0, 1,  1, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  1, 0, 1, 1,  0, 1));
        tbl.push_back(v(30, 1, 1, 0, 1, 1,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(30, 1, 1, 1, 0, 0,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(31, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(30, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(30, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(31, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1));
        tbl.push_back(v(30, 1, 1, 0, 0, 0,  1, 0, 1, 1,  0, 0));
        tbl.push_back(v(30, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0));
        tbl.push_back(v(30, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0));

        bus.alarm_hour  = 5'd7;
        bus.alarm_min   = 6'd30;
        bus.cur_hour    = 5'd7;
        bus.cur_min     = 6'd29;
        bus.alarm_armed = 1'b1;
        bus.clock_mode  = 1'b1;
        bus.tick_1hz    = 1'b0;
        bus.btn_stop    = 1'b0;
        bus.btn_snooze  = 1'b0;
        model_reset();

        #1;
        check("reset ringing",      16'(bus.ringing),      16'd0);
        check("reset buzzer",       16'(bus.buzzer),       16'd0);
        check("reset alarm_led",    16'(bus.alarm_led),    16'd0);
        check("reset snooze_left",  16'(bus.snooze_left),  16'd0);
        check("reset snoozes_used", 16'(bus.snoozes_used), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(7, int'(tbl[i].cm), tbl[i].armed, tbl[i].mode, tbl[i].tick, tbl[i].stop, tbl[i].snz);
            check($sformatf("vec%0d ringing", i),      16'(bus.ringing),      16'(tbl[i].r));
            check($sformatf("vec%0d snoozing", i),     16'(bus.snoozing),     16'(tbl[i].s));
            check($sformatf("vec%0d buzzer", i),       16'(bus.buzzer),       16'(tbl[i].bz));
            check($sformatf("vec%0d alarm_led", i),    16'(bus.alarm_led),    16'(tbl[i].led));
            check($sformatf("vec%0d snooze_left", i),  16'(bus.snooze_left),  16'(tbl[i].left));
            check($sformatf("vec%0d snoozes_used", i), 16'(bus.snoozes_used), 16'(tbl[i].used));
        end

        // Timeout after 60 unattended ticks; no retrigger while time stays at the match.
        trigger("timeout");
        for (int i = 1; i <= RING_TIMEOUT_S; i++) begin
            step(7, 30, 1, 1, 1, 0, 0);
            compare_model("timeout");
            if (i == RING_TIMEOUT_S - 1) check("timeout 59th tick ringing", 16'(bus.ringing), 16'd1);
            step(7, 30, 1, 1, 0, 0, 0);
        end
        check("timeout ringing",   16'(bus.ringing),   16'd0);
        check("timeout buzzer",    16'(bus.buzzer),    16'd0);
        check("timeout alarm_led", 16'(bus.alarm_led), 16'd0);
        repeat (5) step(7, 30, 1, 1, 0, 0, 0);
        check("timeout no retrigger", 16'(bus.ringing), 16'd0);

        // Snooze exhaustion, then stop and snooze together.
        trigger("exhaust");
        for (int k = 1; k <= MAX_SNOOZES; k++) begin
            step(7, 30, 1, 1, 0, 0, 1);
            check($sformatf("exhaust snooze%0d used", k), 16'(bus.snoozes_used), 16'(k));
            check($sformatf("exhaust snooze%0d left", k), 16'(bus.snooze_left),  16'(SNOOZE_S));
            repeat (SNOOZE_S) begin
                step(7, 30, 1, 1, 1, 0, 0);
                compare_model("exhaust");
            end
            check($sformatf("exhaust wake%0d ringing", k), 16'(bus.ringing), 16'd1);
        end
        step(7, 30, 1, 1, 0, 0, 1);
        check("exhaust 4th press ringing",  16'(bus.ringing),      16'd1);
        check("exhaust 4th press snoozing", 16'(bus.snoozing),     16'd0);
        check("exhaust 4th press used",     16'(bus.snoozes_used), 16'd3);
        step(7, 30, 1, 1, 0, 1, 1);
        check("exhaust stop+snooze ringing",  16'(bus.ringing),  16'd0);
        check("exhaust stop+snooze snoozing", 16'(bus.snoozing), 16'd0);

        // Disarm while snoozing; re-arming in the same minute must not ring.
        trigger("disarm");
        step(7, 30, 1, 1, 0, 0, 1);
        step(7, 30, 1, 1, 1, 0, 0);
        check("disarm pre snoozing", 16'(bus.snoozing), 16'd1);
        step(7, 30, 0, 1, 0, 0, 0);
        check("disarm snoozing",  16'(bus.snoozing),  16'd0);
        check("disarm alarm_led", 16'(bus.alarm_led), 16'd0);
        step(7, 30, 1, 1, 0, 0, 0);
        step(7, 30, 1, 1, 0, 0, 0);
        check("rearm same minute ringing", 16'(bus.ringing), 16'd0);

        // Asynchronous reset in the middle of ringing.
        trigger("reset");
        step(7, 30, 1, 1, 1, 0, 0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check("async reset ringing",   16'(bus.ringing),   16'd0);
        check("async reset alarm_led", 16'(bus.alarm_led), 16'd0);
        check("async reset buzzer",    16'(bus.buzzer),    16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(7, 30, 1, 1, 0, 0, 0);
        check("post reset no trigger", 16'(bus.ringing), 16'd0);
        step(7, 31, 1, 1, 0, 0, 0);
        step(7, 30, 1, 1, 0, 0, 0);
        check("post reset next day trigger", 16'(bus.ringing), 16'd1);
        compare_model("post reset");

        // Random phase against the reference model.
        begin
            int  hr, mn;
            bit  armed, mode, tick, stop, snz;
            hr = 7; mn = 30; armed = 1'b1; mode = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(19) == 0) begin
                    mn = 29 + int'($urandom_range(2));
                    hr = ($urandom_range(7) == 0) ? 8 : 7;
                end
                if ($urandom_range(199) == 0) armed = ~armed;
                if ($urandom_range(99) == 0)  mode  = ~mode;
                tick = ($urandom_range(2) == 0);
                stop = !tick && ($urandom_range(39) == 0);
                snz  = !tick && ($urandom_range(7) == 0);
                step(hr, mn, armed, mode, tick, stop, snz);
                compare_model("random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Alarm controller for the digital alarm clock.
- Compares the running time against the stored alarm time and starts a ringing sequence on a match.
- Sequences buzzer and LED blinking, snooze intervals, and stop/timeout handling.
- Sits beside the mode FSM and counter datapath. Consumes the debounced button pulses and the 1 Hz tick, and drives the buzzer and alarm LED.

Parameters:
RING_TIMEOUT_S, 60, seconds of unattended ringing before auto-stop (1..255)
SNOOZE_S, 300, snooze interval in seconds (2..511)
MAX_SNOOZES, 3, snoozes allowed per alarm event (0..7)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
tick_1hz  in  1  one-clk-cycle pulse, once per second
cur_hour  in  5  current hour 0..23
cur_min  in  6  current minute 0..59
alarm_hour  in  5  stored alarm hour 0..23
alarm_min  in  6  stored alarm minute 0..59
alarm_armed  in  1  level; alarm enabled
clock_mode  in  1  level; 1 when mode FSM is in normal clock mode
btn_stop  in  1  one-cycle debounced pulse
btn_snooze  in  1  one-cycle debounced pulse
ringing  out  1  state == RING
snoozing  out  1  state == SNOOZE
buzzer  out  1  gated buzzer drive
alarm_led  out  1  alarm indicator LED
snooze_left  out  9  seconds remaining in current snooze; 0 outside SNOOZE
snoozes_used  out  3  snoozes consumed in current event

Behaviour:
- States: IDLE, RING, SNOOZE. Encoding is free. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; ringing, snoozing, buzzer, alarm_led = 0; snooze_left=0; snoozes_used=0; blink=0; ring_cnt=0.
- Reset value of match_d is 1. A match already present when reset releases does not trigger.
- match = (cur_hour==alarm_hour) & (cur_min==alarm_min), evaluated combinationally. match_d is match registered every cycle. match_rise = match & ~match_d.
- IDLE -> RING when match_rise & alarm_armed & clock_mode.
  - On entry: ring_cnt=0, blink=1, snoozes_used=0.
  - Latency: ringing=1 one clk after the cycle in which match_rise is seen.
- RING, priority highest first:
  1. ~alarm_armed -> IDLE.
  2. btn_stop -> IDLE.
  3. btn_snooze & snoozes_used<MAX_SNOOZES -> SNOOZE; snooze_left=SNOOZE_S; snoozes_used+1.
  4. btn_snooze with snoozes exhausted is ignored; stay in RING.
  5. tick_1hz & ring_cnt==RING_TIMEOUT_S-1 -> IDLE (timeout).
  6. Otherwise, on tick_1hz: ring_cnt+1 and blink toggles.
- SNOOZE, priority highest first:
  1. ~alarm_armed -> IDLE.
  2. btn_stop -> IDLE.
  3. tick_1hz & snooze_left==1 -> RING; ring_cnt=0, blink=1; snoozes_used unchanged.
  4. Otherwise, on tick_1hz: snooze_left-1.
  5. btn_snooze in SNOOZE is ignored.
- Simultaneous btn_stop and btn_snooze: stop wins.
- A button pulse coincident with a tick: the button transition wins; the tick is not applied.
- Entering IDLE from any state clears snooze_left, ring_cnt and blink. snoozes_used holds its value until the next trigger.
- Output decode:
  - buzzer = RING & blink.
  - alarm_led = RING ? blink : SNOOZE ? 1 : 0.
- Retrigger: after stop or timeout inside the matching minute, no retrigger until match falls and rises again.
  - Re-arming during the matching minute does not retrigger, because match_d stays 1.
- Adjust modes (clock_mode=0) block triggering only. An event already in RING or SNOOZE continues regardless of clock_mode.
- tick_1hz is ignored in IDLE. Buttons in IDLE are ignored.
- Counter widths: ring_cnt 8 bits, snooze_left 9 bits, snoozes_used 3 bits. No wrap is possible within the parameter ranges.

Test Plan:
1. Trigger latency. Reset, armed=1, clock_mode=1, alarm=07:30, time steps 07:29 -> 07:30 at cycle N. Required: ringing=1 and buzzer=1 at N+1; buzzer toggles on each tick_1hz.
2. Timeout. Ring with no buttons for 60 ticks. Required: IDLE after the 60th tick, buzzer=0, alarm_led=0. Time held at 07:30 must not retrigger.
3. Snooze cycle. Use SNOOZE_S=5 and press snooze in RING. Required: snoozing=1, snooze_left=5, snoozes_used=1, alarm_led=1, buzzer=0. snooze_left counts 4,3,2,1 on ticks, then RING on the 5th tick with ringing=1.
4. Snooze exhaustion. MAX_SNOOZES=3: snooze three times, then press snooze a fourth time in RING. Required: stays RING, snoozes_used=3. A btn_stop plus btn_snooze in the same cycle goes to IDLE.
5. Disarm and mode gating:
   - armed falls in SNOOZE -> IDLE next clk.
   - Match rise with clock_mode=0 -> no ringing.
   - Re-arm during the same minute -> no ringing.
6. Reset during operation. Assert rst=0 mid-RING with time at the match. Required: all outputs 0 immediately. After release with time still 07:30, no trigger; at 07:31 -> 07:30 (next day), a trigger occurs.
